// File: rtl/hc595_chain_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hc595_chain_drv                                               |
// | Purpose  : Serial driver for a cascade of 74HC595 shift registers.       |
// |            Accepts a parallel frame on a load handshake, shifts it out   |
// |            on ds/shcp at sys_clk/CLK_DIV, latches it with stcp and       |
// |            pulses done.                                                  |
// | Option   : HC595_AUTO_REFRESH_EN - continuous refresh with one pending   |
// |            frame buffer (undefined: one-shot frames).                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hc595_chain_drv #(
  parameter int CHAIN_BITS = 16,
  parameter int CLK_DIV    = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CHAIN_BITS-1:0] data_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ds,
  output logic                  shcp,
  output logic                  stcp,
  output logic                  oe
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(CHAIN_BITS);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(CHAIN_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

`ifdef HC595_AUTO_REFRESH_EN
  localparam bit C_ONE_SHOT = 1'b0;
`else
  localparam bit C_ONE_SHOT = 1'b1;
`endif

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BIT_W-1:0]      w_bit_idx;
  logic [CHAIN_BITS-1:0] r_frame;
  logic                  r_busy, r_done, r_ds, r_shcp, r_stcp, r_oe;
  logic                  w_busy_nxt, w_done_nxt, w_ds_nxt, w_shcp_nxt, w_stcp_nxt;
  logic                  w_accept, w_div_wrap, w_latch_end;

  assign w_accept    = load && ready;
  assign w_div_wrap  = (r_div_cnt == C_DIV_LAST);
  assign w_latch_end = (r_state == S_LATCH) && w_div_wrap;

  // Map the bit counter to a frame index according to shift order
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_bit_idx = C_BIT_LAST - r_bit_cnt;
    end else begin : g_lsb_first
      assign w_bit_idx = r_bit_cnt;
    end
  endgenerate

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_div_wrap && (r_bit_cnt == C_BIT_LAST)) w_state_nxt = S_LATCH;
      S_LATCH: if (w_div_wrap) w_state_nxt = C_ONE_SHOT ? S_IDLE : S_SHIFT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Divider and bit counters; both held at zero while idle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      if ((r_state == S_SHIFT) && w_div_wrap)
        r_bit_cnt <= (r_bit_cnt == C_BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
    end
  end

  // Output decode from current state/counters; registered one cycle later
  always_comb begin
    w_busy_nxt = r_busy;
    if ((r_state == S_IDLE) && w_accept)   w_busy_nxt = 1'b1;
    else if (w_latch_end && C_ONE_SHOT)    w_busy_nxt = 1'b0;
    w_done_nxt = w_latch_end;
    w_ds_nxt   = ((r_state == S_SHIFT) && (r_div_cnt == '0)) ? r_frame[w_bit_idx] : r_ds;
    w_shcp_nxt = (r_state == S_SHIFT) && (r_div_cnt >= C_DIV_HALF);
    w_stcp_nxt = (r_state == S_LATCH) && (r_div_cnt >= C_DIV_HALF);
  end

  // Pin/status registers; oe releases on the first latch pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ds   <= 1'b0;
      r_shcp <= 1'b0;
      r_stcp <= 1'b0;
      r_oe   <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_ds   <= w_ds_nxt;
      r_shcp <= w_shcp_nxt;
      r_stcp <= w_stcp_nxt;
      if (w_stcp_nxt) r_oe <= 1'b0;
    end
  end

`ifdef HC595_AUTO_REFRESH_EN
  logic [CHAIN_BITS-1:0] r_pend;
  logic                  r_pend_vld;

  // Frame register plus one-deep pending buffer swapped in at frame end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame    <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_accept && (r_state == S_IDLE)) begin
        r_frame <= data_in;
      end else if (w_accept) begin
        r_pend     <= data_in;
        r_pend_vld <= 1'b1;
      end else if (w_latch_end && r_pend_vld) begin
        r_frame    <= r_pend;
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign ready = ~r_pend_vld;
`else
  // Frame register, captured only when a load is accepted
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    r_frame <= '0;
    else if (w_accept) r_frame <= data_in;
  end

  assign ready = ~r_busy;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign ds   = r_ds;
  assign shcp = r_shcp;
  assign stcp = r_stcp;
  assign oe   = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_hc595_chain_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hc595_chain_drv                                            |
// | Purpose  : Scoreboard bench for hc595_chain_drv (default 16-bit build    |
// |            and a 24-bit LSB-first, CLK_DIV=2 instance).                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hc595_chain_drv;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic [15:0] data_in;
  logic        load;
  logic        ready, busy, done, ds, shcp, stcp, oe;

  logic [23:0] data24;
  logic        load24;
  logic        ready24, busy24, done24, ds24, shcp24, stcp24, oe24;

  hc595_chain_drv dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data_in), .load(load),
    .ready(ready), .busy(busy), .done(done), .ds(ds), .shcp(shcp),
    .stcp(stcp), .oe(oe)
  );

  hc595_chain_drv #(.CHAIN_BITS(24), .CLK_DIV(2), .MSB_FIRST(1'b0)) dut24 (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data24), .load(load24),
    .ready(ready24), .busy(busy24), .done(done24), .ds(ds24), .shcp(shcp24),
    .stcp(stcp24), .oe(oe24)
  );

  int n_vec = 0;
  int n_err = 0;

  bit exp_bits[$];
  int exp_len[$];
  bit exp_bits24[$];
  int exp_len24[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected ds sequence for an MSB-first 16-bit frame
  task automatic push16(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) exp_bits.push_back(v[i]);
    exp_len.push_back(68);
  endtask

  // Monitor for the default instance
  int busy_cnt = 0, stcp_cnt = 0, done_cnt = 0;
  bit shcp_q = 0, stcp_q = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_bits.delete(); exp_len.delete();
      busy_cnt = 0; stcp_cnt = 0; shcp_q = 0; stcp_q = 0;
    end else begin
      if (shcp && !shcp_q) begin
        if (exp_bits.size() == 0) check("unexpected shcp rise", 1, 0);
        else                      check("ds at shcp rise", ds, exp_bits.pop_front());
      end
      if (busy) busy_cnt++;
      if (stcp) stcp_cnt++;
      if (!stcp && stcp_q) begin
        check("stcp width", stcp_cnt, 2);
        stcp_cnt = 0;
      end
      if (done) begin
        done_cnt++;
        check("stcp high with done", stcp, 1);
        check("ready with done", ready, 1);
        if (exp_len.size() == 0) check("unexpected done", 1, 0);
        else                     check("busy length", busy_cnt, exp_len.pop_front());
        busy_cnt = 0;
      end
      shcp_q = shcp; stcp_q = stcp;
    end
  end

  // Monitor for the 24-bit instance
  int busy24_cnt = 0, done24_cnt = 0, cyc24 = 0, last_rise24 = -1;
  bit shcp24_q = 0;
  always @(negedge clk) begin
    cyc24++;
    if (!rst_n) begin
      exp_bits24.delete(); exp_len24.delete();
      busy24_cnt = 0; shcp24_q = 0; last_rise24 = -1;
    end else begin
      if (shcp24 && !shcp24_q) begin
        if (exp_bits24.size() == 0) check("unexpected shcp24 rise", 1, 0);
        else                        check("ds24 at shcp rise", ds24, exp_bits24.pop_front());
        if (last_rise24 >= 0) check("shcp24 period", cyc24 - last_rise24, 2);
        last_rise24 = cyc24;
      end
      if (busy24) busy24_cnt++;
      if (done24) begin
        done24_cnt++;
        if (exp_len24.size() == 0) check("unexpected done24", 1, 0);
        else                       check("busy24 length", busy24_cnt, exp_len24.pop_front());
        busy24_cnt = 0;
        last_rise24 = -1;
      end
      shcp24_q = shcp24;
    end
  end

  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done timeout", 0, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " ready"}, ready, 1);
    check({tag, " busy"},  busy,  0);
    check({tag, " done"},  done,  0);
    check({tag, " ds"},    ds,    0);
    check({tag, " shcp"},  shcp,  0);
    check({tag, " stcp"},  stcp,  0);
    check({tag, " oe"},    oe,    1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; load = 1'b0; data_in = '0; load24 = 1'b0; data24 = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Single A5C3 frame, MSB first
    push16(16'hA5C3);
    data_in = 16'hA5C3; load = 1'b1;
    @(negedge clk) load = 1'b0;
    repeat (20) @(negedge clk);
    check("oe before first latch", oe, 1);
    check("ready while busy", ready, 0);
    wait_done(200);
    @(negedge clk);
    check("oe after first latch", oe, 0);
    check("idle after done", busy, 0);

    // Load of FFFF mid-frame is ignored
    push16(16'hA5C3);
    data_in = 16'hA5C3; load = 1'b1;
    @(negedge clk) load = 1'b0;
    repeat (20) @(negedge clk);
    check("ready mid-frame", ready, 0);
    data_in = 16'hFFFF; load = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
    wait_done(200);
    @(negedge clk);

    // Asynchronous reset during bit 7, then a clean 00FF frame
    push16(16'hA5C3);
    data_in = 16'hA5C3; load = 1'b1;
    @(negedge clk) load = 1'b0;
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outs("async reset");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    push16(16'h00FF);
    data_in = 16'h00FF; load = 1'b1;
    @(negedge clk) load = 1'b0;
    wait_done(200);
    @(negedge clk);
    check("oe after post-reset latch", oe, 0);

    // Load held high: back-to-back frames with a single idle cycle
    push16(16'hC3A5);
    push16(16'hC3A5);
    data_in = 16'hC3A5; load = 1'b1;
    wait_done(200);
    k = 0;
    @(negedge clk);
    k++;
    check("busy right after done cycle", busy, 1);
    load = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done-to-done period", k, 69);
    @(negedge clk);

    // 24-bit LSB-first instance, CLK_DIV=2
    exp_bits24.push_back(1'b1);
    for (int i = 0; i < 23; i++) exp_bits24.push_back(1'b0);
    exp_len24.push_back(50);
    data24 = 24'h000001; load24 = 1'b1;
    @(negedge clk) load24 = 1'b0;
    k = 0;
    while (!done24 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done24) check("done24 timeout", 0, 1);
    repeat (4) @(negedge clk);

    check("leftover expected bits", exp_bits.size(), 0);
    check("leftover expected bits24", exp_bits24.size(), 0);
    check("frames completed", done_cnt, 5);
    check("frames24 completed", done24_cnt, 1);
    check("oe24 after latch", oe24, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hc595_chain_drv.md
# hc595_chain_drv

Parametrised serial driver for a cascade of 74HC595 shift registers, successor to the fixed 16-bit, free-running digit/segment shifter. It takes a parallel frame of any multiple-of-8 width and a load handshake, then shifts the frame out on ds/shcp at a configurable divided rate. It pulses stcp to latch the chain and reports completion. It sits between display/LED scan logic and the board pins.

## Interface
- CHAIN_BITS, 16: total bits in the cascade; multiple of 8, ≥8.
- CLK_DIV, 4: sys_clk cycles per shcp period; even, ≥2.
- MSB_FIRST, 1: 1 shifts data_in[CHAIN_BITS-1] first; 0 shifts data_in[0] first.
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- data_in  in  CHAIN_BITS  frame to send; sampled only on acceptance.
- load  in  1  frame request; accepted on a rising edge where load && ready.
- ready  out  1  a load would be accepted this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- ds  out  1  serial data to the first 74HC595.
- shcp  out  1  shift clock.
- stcp  out  1  storage latch clock.
- oe  out  1  74HC595 output enable, active-low.

## Operation
- FSM: IDLE → SHIFT → LATCH → IDLE. Counters: div_cnt 0..CLK_DIV-1, bit_cnt 0..CHAIN_BITS-1.
- IDLE: div_cnt=0, bit_cnt=0. On acceptance, data_in is copied to the frame register, busy←1, state←SHIFT.
- SHIFT:
  - div_cnt wraps at CLK_DIV-1. bit_cnt increments on each wrap.
  - After bit CHAIN_BITS-1 wraps, state←LATCH.
- LATCH: lasts CLK_DIV cycles. At its last cycle: state←IDLE, busy←0, done←1 for one cycle.
- Outputs are registered and reflect the (state, counters) of the previous cycle:
  - ds ← current bit when SHIFT && div_cnt==0; ds holds otherwise.
  - shcp ← SHIFT && div_cnt ≥ CLK_DIV/2.
  - stcp ← LATCH && div_cnt ≥ CLK_DIV/2.
- Bit selection: bit index is bit_cnt when MSB_FIRST=0, and CHAIN_BITS-1-bit_cnt when MSB_FIRST=1.
- oe: 1 from reset until the first stcp rising edge, then 0. This keeps garbage from being displayed after power-up.
- Without the macro, ready = ~busy. load while busy is ignored and data_in is not sampled.
- Asynchronous reset at any time: state IDLE, counters 0, frame discarded. Outputs: ready=1, busy=0, done=0, ds=0, shcp=0, stcp=0, oe=1.

## Timing
- Acceptance at edge E0: busy=1 from E0 for exactly (CHAIN_BITS+1)·CLK_DIV cycles. Defaults give 68.
- ds changes 1 cycle after div_cnt reaches 0. shcp rises CLK_DIV/2 cycles after each ds change, so setup is CLK_DIV/2 cycles.
- Exactly CHAIN_BITS shcp rising edges per frame; shcp is 0 in IDLE and LATCH.
- stcp is high for CLK_DIV/2 cycles; its last high cycle coincides with done=1.
- The done cycle is IDLE with ready=1. A load held high there starts the next frame at the following edge. Minimum frame-to-frame period is (CHAIN_BITS+1)·CLK_DIV+1 cycles.
- ds holds its last bit in IDLE.

## Configuration
- HC595_AUTO_REFRESH_EN defined:
  - After the first accepted frame, the block never returns to IDLE. LATCH goes directly to SHIFT; busy stays 1; done pulses at every frame end.
  - A load accepted while busy captures data_in into a pending register, and ready←0 until consumed.
  - At a frame end, a pending frame becomes the next frame and ready←1. Otherwise the current frame is resent.
  - Inter-frame period is (CHAIN_BITS+1)·CLK_DIV cycles.
- HC595_AUTO_REFRESH_EN undefined: one-shot behaviour as described above; no pending register.

## Test plan
- Defaults, data_in=16'hA5C3, 1-cycle load → ds sampled at the 16 shcp rises is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. Exactly one stcp pulse, 2 cycles wide. done at cycle 68 after acceptance. oe falls after stcp.
- load re-asserted with data_in=16'hFFFF mid-frame (macro off) → ignored; frame still shifts A5C3; busy length unchanged.
- CHAIN_BITS=24, CLK_DIV=2, MSB_FIRST=0, data_in=24'h000001 → first shifted bit is 1, remaining 23 are 0. busy lasts 50 cycles; shcp period 2 cycles.
- sys_rst_n pulsed low at bit 7 → all outputs take their reset values immediately, and oe=1. After release, a new load of 16'h00FF completes normally in 68 cycles.
- load held high continuously (macro off) → frames back-to-back, with one IDLE cycle between done and the next busy rise.
- Macro on: load 16'h1234, then load 16'h5678 mid-frame → ready=0 until the frame end. The frame after 1234 is 5678, then 5678 repeats. done pulses every 68 cycles.
